// File: rtl/comp_arbiter.sv
// comp_arbiter: round-robin arbiter sharing one external two's-complement unit (COMP)
// between two requesters. The winner's operand is steered onto comp_a, the COMP result is
// captured in a one-entry output slot tagged with the requester ID, and a saturating
// 16-bit grant count is kept per requester.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req0_valid/req0_a/ready   requester 0 handshake and 32-bit operand
//   req1_valid/req1_a/ready   requester 1 handshake and 32-bit operand
//   comp_a / comp_b           operand to / result from the shared COMP instance
//   rsp_valid/rsp_id/rsp_b    registered result slot, rsp_ready accepts it
//   grant_cnt0/grant_cnt1     saturating per-requester grant counts
module comp_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [31:0] req0_a,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_a,
   output logic        req1_ready,
   output logic [31:0] comp_a,
   input  logic [31:0] comp_b,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [31:0] rsp_b,
   input  logic        rsp_ready,
   output logic [15:0] grant_cnt0,
   output logic [15:0] grant_cnt1
);

   typedef enum logic {StEmpty, StFull} slot_state_e;

   slot_state_e state_q;
   logic        last_grant_q;
   logic        rsp_id_q;
   logic [31:0] rsp_b_q;
   logic [15:0] cnt0_q;
   logic [15:0] cnt1_q;

   logic slot_free;
   logic grant0;
   logic grant1;
   logic grant_any;

   // The slot can accept a new result if it is empty or being drained this cycle.
   assign slot_free = (state_q == StEmpty) || rsp_ready;

   // On a tie the requester that did not win last time gets the slot. Nothing is granted
   // while reset is high, so no operand is consumed and then discarded.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rst && slot_free) begin
         grant0 = req0_valid && (!req1_valid || last_grant_q);
         grant1 = req1_valid && (!req0_valid || !last_grant_q);
      end
   end

   assign grant_any  = grant0 || grant1;
   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      comp_a = 32'h0000_0000;
      if (grant0) begin
         comp_a = req0_a;
      end else if (grant1) begin
         comp_a = req1_a;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StEmpty;
         last_grant_q <= 1'b1;
         rsp_id_q     <= 1'b0;
         rsp_b_q      <= 32'h0000_0000;
         cnt0_q       <= 16'h0000;
         cnt1_q       <= 16'h0000;
      end else begin
         case (state_q)
            StEmpty: begin
               if (grant_any) state_q <= StFull;
            end
            StFull: begin
               if (rsp_ready && !grant_any) state_q <= StEmpty;
            end
            default: state_q <= StEmpty;
         endcase

         if (grant_any) begin
            rsp_b_q      <= comp_b;
            rsp_id_q     <= grant1;
            last_grant_q <= grant1;
         end
         if (grant0 && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
         if (grant1 && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
      end
   end

   assign rsp_valid  = (state_q == StFull);
   assign rsp_id     = rsp_id_q;
   assign rsp_b      = rsp_b_q;
   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_comp_arbiter.sv
module tb_comp_arbiter;

   logic        clk;
   logic        rst;
   logic        req0_valid;
   logic [31:0] req0_a;
   logic        req0_ready;
   logic        req1_valid;
   logic [31:0] req1_a;
   logic        req1_ready;
   logic [31:0] comp_a;
   logic [31:0] comp_b;
   logic        rsp_valid;
   logic        rsp_id;
   logic [31:0] rsp_b;
   logic        rsp_ready;
   logic [15:0] grant_cnt0;
   logic [15:0] grant_cnt1;

   int checks;
   int failures;

   comp_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_ready (req1_ready),
      .comp_a     (comp_a),
      .comp_b     (comp_b),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_b      (rsp_b),
      .rsp_ready  (rsp_ready),
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1)
   );

   // Model of the shared COMP unit.
   assign comp_b = ~comp_a + 32'd1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] last_a;

   initial begin
      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      req0_valid = 1'b0;
      req0_a     = 32'h0;
      req1_valid = 1'b0;
      req1_a     = 32'h0;
      rsp_ready  = 1'b0;
      tick();
      // Readies stay low during reset even with a request present.
      req0_valid = 1'b1;
      req0_a     = 32'h0000_0002;
      #1;
      check("rst_ready0", {31'b0, req0_ready}, 32'd0);
      check("rst_comp_a", comp_a, 32'h0);
      tick();
      check("rst_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_id", {31'b0, rsp_id}, 32'd0);
      check("rst_b", rsp_b, 32'h0);
      check("rst_cnt0", {16'b0, grant_cnt0}, 32'd0);
      check("rst_cnt1", {16'b0, grant_cnt1}, 32'd0);

      // Single requester 0.
      rst       = 1'b0;
      rsp_ready = 1'b1;
      #1;
      check("t1_ready0", {31'b0, req0_ready}, 32'd1);
      check("t1_ready1", {31'b0, req1_ready}, 32'd0);
      check("t1_comp_a", comp_a, 32'h0000_0002);
      tick();
      req0_valid = 1'b0;
      check("t1_valid", {31'b0, rsp_valid}, 32'd1);
      check("t1_id", {31'b0, rsp_id}, 32'd0);
      check("t1_b", rsp_b, 32'hFFFF_FFFE);
      check("t1_cnt0", {16'b0, grant_cnt0}, 32'd1);

      // Re-reset so the tie sequence starts with requester 0.
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // Both valid: alternate 0,1,0,1.
      req0_valid = 1'b1;
      req0_a     = 32'h0000_0003;
      req1_valid = 1'b1;
      req1_a     = 32'h8000_001E;
      rsp_ready  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t2_ready0", {31'b0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check("t2_ready1", {31'b0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
         tick();
         check("t2_id", {31'b0, rsp_id}, (i % 2 == 1) ? 32'd1 : 32'd0);
         check("t2_b", rsp_b, (i % 2 == 1) ? 32'h7FFF_FFE2 : 32'hFFFF_FFFD);
      end
      check("t2_cnt0", {16'b0, grant_cnt0}, 32'd2);
      check("t2_cnt1", {16'b0, grant_cnt1}, 32'd2);

      // Back-pressure with req1 pending.
      req0_valid = 1'b0;
      req1_a     = 32'h0000_0005;
      rsp_ready  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t3_ready1", {31'b0, req1_ready}, 32'd0);
         check("t3_comp_a", comp_a, 32'h0);
         tick();
         check("t3_valid", {31'b0, rsp_valid}, 32'd1);
         check("t3_b_hold", rsp_b, 32'h7FFF_FFE2);
      end
      rsp_ready = 1'b1;
      #1;
      check("t3_ready1_rise", {31'b0, req1_ready}, 32'd1);
      check("t3_comp_a_rise", comp_a, 32'h0000_0005);
      tick();
      req1_valid = 1'b0;
      check("t3_b", rsp_b, 32'hFFFF_FFFB);
      check("t3_id", {31'b0, rsp_id}, 32'd1);
      check("t3_cnt1", {16'b0, grant_cnt1}, 32'd3);
      tick();
      check("t3_drain_valid", {31'b0, rsp_valid}, 32'd0);
      check("t3_drain_b_hold", rsp_b, 32'hFFFF_FFFB);

      // Boundary operands; rsp_ready is ignored while the slot is empty.
      rsp_ready  = 1'b0;
      req0_valid = 1'b1;
      req0_a     = 32'h8000_0000;
      #1;
      check("t4_ready0_empty", {31'b0, req0_ready}, 32'd1);
      tick();
      req0_valid = 1'b0;
      check("t4_b_min", rsp_b, 32'h8000_0000);
      check("t4_id0", {31'b0, rsp_id}, 32'd0);
      rsp_ready  = 1'b1;
      req1_valid = 1'b1;
      req1_a     = 32'h0;
      tick();
      req1_valid = 1'b0;
      check("t4_b_zero", rsp_b, 32'h0);
      check("t4_id1", {31'b0, rsp_id}, 32'd1);
      check("t4_cnt1", {16'b0, grant_cnt1}, 32'd4);

      // Saturation of grant_cnt0 (starts at 3).
      req0_valid = 1'b1;
      last_a     = 32'h0;
      for (int i = 0; i < 70000; i++) begin
         last_a = i * 7 + 1;
         req0_a = last_a;
         tick();
      end
      check("t5_cnt0_sat", {16'b0, grant_cnt0}, 32'h0000_FFFF);
      check("t5_b", rsp_b, ~last_a + 32'd1);
      check("t5_cnt1", {16'b0, grant_cnt1}, 32'd4);

      // Arbitration still alternates after saturation (last grant was 0).
      req0_a     = 32'h0000_0010;
      req1_valid = 1'b1;
      req1_a     = 32'h0000_0020;
      #1;
      check("t5_tie_ready1", {31'b0, req1_ready}, 32'd1);
      tick();
      check("t5_tie_b1", rsp_b, 32'hFFFF_FFE0);
      #1;
      check("t5_tie_ready0", {31'b0, req0_ready}, 32'd1);
      tick();
      check("t5_tie_b0", rsp_b, 32'hFFFF_FFF0);
      check("t5_cnt0_hold", {16'b0, grant_cnt0}, 32'h0000_FFFF);

      // Reset with a full slot and both requests pending.
      rst = 1'b1;
      #1;
      check("t6_rst_ready0", {31'b0, req0_ready}, 32'd0);
      check("t6_rst_ready1", {31'b0, req1_ready}, 32'd0);
      tick();
      rst = 1'b0;
      check("t6_valid", {31'b0, rsp_valid}, 32'd0);
      check("t6_cnt0", {16'b0, grant_cnt0}, 32'd0);
      check("t6_cnt1", {16'b0, grant_cnt1}, 32'd0);
      #1;
      check("t6_first_ready0", {31'b0, req0_ready}, 32'd1);
      check("t6_first_ready1", {31'b0, req1_ready}, 32'd0);
      tick();
      check("t6_first_id", {31'b0, rsp_id}, 32'd0);
      check("t6_first_b", rsp_b, 32'hFFFF_FFF0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
